// File: rtl/cpu_defs.sv
// Shared encodings for the multi-cycle MIPS-subset control path:
// opcodes, ALU operation classes, mux selects and the main FSM states.
package cpu_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_RS = 1'b1;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEMACC,
        ST_WBACK,
        ST_TRAP
    } state_t;

    function automatic logic op_legal(input logic [5:0] opc);
        return (opc == OP_RTYPE) || (opc == OP_LW) || (opc == OP_SW) ||
               (opc == OP_BEQ)   || (opc == OP_ORI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle core: sequences each instruction, owns the
// memory handshake with its wait timeout, the sticky trap and the retire counter.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             runEn,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             memAck,
    output logic             memReq,
    output logic             memRdSig,
    output logic             memWrSig,
    output logic             irWrSig,
    output logic             pcWrSig,
    output logic [1:0]       pcSrcSig,
    output logic             aluSrcASig,
    output logic [1:0]       aluSrcBSig,
    output logic [1:0]       aluOpSig,
    output logic             aluImmSig,
    output logic             regDstSig,
    output logic             regWrSig,
    output logic             memToRegSig,
    output logic             trapSig,
    output logic             busySig,
    output logic [CNT_W-1:0] instRetired
);
    import cpu_defs::*;

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t            state;
    state_t            next;
    logic [5:0]        opReg;
    logic [WAIT_W-1:0] waitCnt;
    logic              retire;
    logic              waitExpired;

    // Last permitted wait cycle with no acknowledge; an ack in that cycle still wins.
    assign waitExpired = (MEM_TIMEOUT != 0) && (waitCnt == WAIT_LAST) && !memAck;

    always_comb begin
        next        = state;
        retire      = 1'b0;
        memReq      = 1'b0;
        memRdSig    = 1'b0;
        memWrSig    = 1'b0;
        irWrSig     = 1'b0;
        pcWrSig     = 1'b0;
        pcSrcSig    = PCSRC_ALU;
        aluSrcASig  = SRCA_PC;
        aluSrcBSig  = SRCB_RT;
        aluOpSig    = ALUOP_ADD;
        aluImmSig   = 1'b0;
        regDstSig   = 1'b0;
        regWrSig    = 1'b0;
        memToRegSig = 1'b0;
        trapSig     = 1'b0;
        busySig     = (state != ST_IDLE) && (state != ST_TRAP);

        case (state)
            ST_IDLE: begin
                if (runEn) next = ST_FETCH;
            end

            ST_FETCH: begin
                memReq     = 1'b1;
                memRdSig   = 1'b1;
                aluSrcASig = SRCA_PC;
                aluSrcBSig = SRCB_FOUR;
                aluOpSig   = ALUOP_ADD;
                if (memAck) begin
                    irWrSig  = 1'b1;
                    pcWrSig  = 1'b1;
                    pcSrcSig = PCSRC_ALU;
                    next     = ST_DECODE;
                end else if (waitExpired) begin
                    next = ST_TRAP;
                end
            end

            ST_DECODE: begin
                aluSrcASig = SRCA_PC;
                aluSrcBSig = SRCB_IMM_SH2;
                aluOpSig   = ALUOP_ADD;
                next       = op_legal(op) ? ST_EXEC : ST_TRAP;
            end

            ST_EXEC: begin
                aluSrcASig = SRCA_RS;
                case (opReg)
                    OP_RTYPE: begin
                        aluSrcBSig = SRCB_RT;
                        aluOpSig   = ALUOP_FUNCT;
                        next       = ST_WBACK;
                    end
                    OP_LW, OP_SW: begin
                        aluSrcBSig = SRCB_IMM;
                        aluOpSig   = ALUOP_ADD;
                        next       = ST_MEMACC;
                    end
                    OP_ORI: begin
                        aluSrcBSig = SRCB_IMM;
                        aluOpSig   = ALUOP_OR;
                        aluImmSig  = 1'b1;
                        next       = ST_WBACK;
                    end
                    OP_BEQ: begin
                        aluSrcBSig = SRCB_RT;
                        aluOpSig   = ALUOP_SUB;
                        pcSrcSig   = PCSRC_ALUOUT;
                        pcWrSig    = zero;
                        retire     = 1'b1;
                    end
                    default: next = ST_TRAP;
                endcase
            end

            ST_MEMACC: begin
                memReq   = 1'b1;
                memRdSig = (opReg == OP_LW);
                memWrSig = (opReg == OP_SW);
                if (memAck) begin
                    if (opReg == OP_LW) next = ST_WBACK;
                    else                retire = 1'b1;
                end else if (waitExpired) begin
                    next = ST_TRAP;
                end
            end

            ST_WBACK: begin
                regWrSig    = 1'b1;
                regDstSig   = (opReg == OP_RTYPE);
                memToRegSig = (opReg == OP_LW);
                retire      = 1'b1;
            end

            ST_TRAP: begin
                trapSig = 1'b1;
            end

            default: next = ST_IDLE;
        endcase

        // runEn only matters at the instruction boundary
        if (retire) next = runEn ? ST_FETCH : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            opReg       <= '0;
            waitCnt     <= '0;
            instRetired <= '0;
        end else begin
            state <= next;
            if (state == ST_DECODE) opReg <= op;
            if (state != ST_TRAP) begin
                if (memReq && !memAck && (next == state)) waitCnt <= waitCnt + 1'b1;
                else                                       waitCnt <= '0;
            end
            if (retire) instRetired <= instRetired + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-level bench for multicycle_ctrl: each instruction's
// expected per-cycle control vector is derived from its opcode and handshake delays.
module tb_multicycle_ctrl;

    localparam int CW  = 4;
    localparam int TMO = 15;

    localparam logic [5:0] R_OP   = 6'b000000;
    localparam logic [5:0] LW_OP  = 6'b100011;
    localparam logic [5:0] SW_OP  = 6'b101011;
    localparam logic [5:0] BEQ_OP = 6'b000100;
    localparam logic [5:0] ORI_OP = 6'b001101;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          runEn;
    logic [5:0]    op;
    logic          zero;
    logic          memAck;
    logic          memReq, memRdSig, memWrSig, irWrSig, pcWrSig;
    logic [1:0]    pcSrcSig;
    logic          aluSrcASig;
    logic [1:0]    aluSrcBSig, aluOpSig;
    logic          aluImmSig, regDstSig, regWrSig, memToRegSig, trapSig, busySig;
    logic [CW-1:0] instRetired;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .runEn(runEn), .op(op), .zero(zero), .memAck(memAck),
        .memReq(memReq), .memRdSig(memRdSig), .memWrSig(memWrSig), .irWrSig(irWrSig),
        .pcWrSig(pcWrSig), .pcSrcSig(pcSrcSig), .aluSrcASig(aluSrcASig),
        .aluSrcBSig(aluSrcBSig), .aluOpSig(aluOpSig), .aluImmSig(aluImmSig),
        .regDstSig(regDstSig), .regWrSig(regWrSig), .memToRegSig(memToRegSig),
        .trapSig(trapSig), .busySig(busySig), .instRetired(instRetired)
    );

    typedef struct packed {
        logic       memReq, memRd, memWr, irWr, pcWr;
        logic [1:0] pcSrc;
        logic       aluA;
        logic [1:0] aluB, aluOp;
        logic       aluImm, regDst, regWr, memToReg, trap, busy;
    } outs_t;

    outs_t got;
    assign got = {memReq, memRdSig, memWrSig, irWrSig, pcWrSig, pcSrcSig, aluSrcASig,
                  aluSrcBSig, aluOpSig, aluImmSig, regDstSig, regWrSig, memToRegSig,
                  trapSig, busySig};

    int          tests = 0;
    int          fails = 0;
    int          cycles = 0;
    int unsigned exp_ret = 0;

    function automatic bit legal(input logic [5:0] o);
        return o == R_OP || o == LW_OP || o == SW_OP || o == BEQ_OP || o == ORI_OP;
    endfunction

    function automatic outs_t busy_vec();
        outs_t o = '0;
        o.busy = 1'b1;
        return o;
    endfunction

    task automatic noise();
        op     = 6'($urandom);
        zero   = 1'($urandom);
        runEn  = 1'($urandom);
        memAck = 1'($urandom);
    endtask

    task automatic check(input outs_t e, input string name);
        logic [CW-1:0] er;
        #1;
        er = exp_ret[CW-1:0];
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s: outputs got=%b exp=%b", name, got, e);
        end
        tests++;
        if (instRetired !== er) begin
            fails++;
            $display("FAIL %s_retired: got=%0d exp=%0d", name, instRetired, er);
        end
    endtask

    task automatic pin(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got=%0d exp=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cycles++;
    endtask

    // One memory wait phase: ack arrives in cycle index dly (dly >= TMO never acks).
    task automatic mem_phase(input outs_t base, input int dly, input logic is_fetch,
                             input logic retire_on_ack, input logic run_after,
                             output bit acked);
        outs_t e;
        acked = 1'b0;
        for (int i = 0; i < TMO && !acked; i++) begin
            noise();
            memAck = (i == dly);
            if (memAck && retire_on_ack) runEn = run_after;
            e = base;
            if (memAck && is_fetch) begin
                e.irWr = 1'b1;
                e.pcWr = 1'b1;
            end
            check(e, is_fetch ? "fetch" : "memacc");
            acked = memAck;
            tick();
        end
    endtask

    task automatic run_inst(input logic [5:0] opc, input int fdly, input int mdly,
                            input logic zr, input logic run_after, output bit trapped);
        outs_t e;
        bit    acked;
        trapped = 1'b0;

        e = busy_vec(); e.memReq = 1'b1; e.memRd = 1'b1; e.aluB = 2'b01;
        mem_phase(e, fdly, 1'b1, 1'b0, run_after, acked);
        if (!acked) begin trapped = 1'b1; return; end

        noise(); op = opc;
        e = busy_vec(); e.aluB = 2'b11;
        check(e, "decode");
        tick();
        if (!legal(opc)) begin trapped = 1'b1; return; end

        noise(); zero = zr;
        e = busy_vec(); e.aluA = 1'b1;
        case (opc)
            R_OP:         begin e.aluB = 2'b00; e.aluOp = 2'b10; end
            ORI_OP:       begin e.aluB = 2'b10; e.aluOp = 2'b11; e.aluImm = 1'b1; end
            BEQ_OP:       begin e.aluB = 2'b00; e.aluOp = 2'b01; e.pcSrc = 2'b01;
                                e.pcWr = zr; runEn = run_after; end
            default:      begin e.aluB = 2'b10; e.aluOp = 2'b00; end
        endcase
        check(e, "exec");
        tick();
        if (opc == BEQ_OP) begin exp_ret++; return; end

        if (opc == LW_OP || opc == SW_OP) begin
            e = busy_vec(); e.memReq = 1'b1;
            e.memRd = (opc == LW_OP);
            e.memWr = (opc == SW_OP);
            mem_phase(e, mdly, 1'b0, opc == SW_OP, run_after, acked);
            if (!acked) begin trapped = 1'b1; return; end
            if (opc == SW_OP) begin exp_ret++; return; end
        end

        noise(); runEn = run_after;
        e = busy_vec(); e.regWr = 1'b1;
        e.regDst = (opc == R_OP);
        e.memToReg = (opc == LW_OP);
        check(e, "wback");
        tick();
        exp_ret++;
    endtask

    // n idle cycles with runEn low, then one idle cycle that starts execution
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            noise(); runEn = 1'b0;
            check('0, "idle");
            tick();
        end
        noise(); runEn = 1'b1;
        check('0, "idle_go");
        tick();
    endtask

    task automatic trap_hold(input int n);
        outs_t e;
        e = '0; e.trap = 1'b1;
        for (int i = 0; i < n; i++) begin
            noise(); runEn = 1'b1;
            check(e, "trap_hold");
            tick();
        end
    endtask

    // memAck held high while reset falls: no fetch enable may leak out
    task automatic do_reset();
        noise(); memAck = 1'b1;
        rst_n = 1'b0;
        exp_ret = 0;
        check('0, "reset");
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit trapped;
        int c0;
        logic [5:0] opc;
        int fd, md;

        rst_n = 1'b0; runEn = 1'b0; op = '0; zero = 1'b0; memAck = 1'b0;
        @(negedge clk);
        check('0, "reset_state");
        pin("reset_retired", int'(instRetired), 0);
        tick();
        rst_n = 1'b1;
        idle(2);

        c0 = cycles;
        run_inst(R_OP, 0, 0, 1'b0, 1'b1, trapped);
        pin("rtype_cycles", cycles - c0, 4);
        pin("rtype_retired", int'(instRetired), 1);

        // each wait phase lasts delay+1 cycles: 4 + 1 + 1 + 4 + 1
        c0 = cycles;
        run_inst(LW_OP, 3, 3, 1'b0, 1'b1, trapped);
        pin("lw_cycles", cycles - c0, 11);
        pin("lw_retired", int'(instRetired), 2);

        c0 = cycles;
        run_inst(BEQ_OP, 0, 0, 1'b1, 1'b1, trapped);
        pin("beq_taken_cycles", cycles - c0, 3);
        c0 = cycles;
        run_inst(BEQ_OP, 0, 0, 1'b0, 1'b1, trapped);
        pin("beq_nt_cycles", cycles - c0, 3);
        run_inst(ORI_OP, 1, 0, 1'b0, 1'b1, trapped);
        run_inst(SW_OP, 0, 2, 1'b0, 1'b0, trapped);
        pin("sw_retired", int'(instRetired), 6);
        idle(3);

        run_inst(6'b111111, 0, 0, 1'b0, 1'b1, trapped);
        pin("illegal_trapped", int'(trapped), 1);
        trap_hold(20);
        do_reset();
        idle(1);

        c0 = cycles;
        run_inst(R_OP, 99, 0, 1'b0, 1'b1, trapped);
        pin("fetch_timeout_trapped", int'(trapped), 1);
        pin("fetch_timeout_cycles", cycles - c0, 15);
        trap_hold(3);
        do_reset();
        idle(0);

        c0 = cycles;
        run_inst(R_OP, 14, 0, 1'b0, 1'b1, trapped);
        pin("late_ack_trapped", int'(trapped), 0);
        pin("late_ack_cycles", cycles - c0, 18);

        do_reset();
        idle(0);

        run_inst(LW_OP, 0, 99, 1'b0, 1'b1, trapped);
        pin("memacc_timeout_trapped", int'(trapped), 1);
        trap_hold(2);
        do_reset();
        idle(0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 19))
                0:       opc = ($urandom_range(0, 1) == 0) ? 6'b111111 : 6'b000010;
                1, 2, 3: opc = R_OP;
                4, 5, 6, 7: opc = LW_OP;
                8, 9, 10: opc = SW_OP;
                11, 12, 13, 14: opc = BEQ_OP;
                default: opc = ORI_OP;
            endcase
            fd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 16)) : int'($urandom_range(0, 4));
            md = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 16)) : int'($urandom_range(0, 4));
            run_inst(opc, fd, md, 1'($urandom), ($urandom_range(0, 7) != 0), trapped);
            if (trapped) begin
                trap_hold(int'($urandom_range(2, 5)));
                do_reset();
                idle(int'($urandom_range(0, 2)));
            end else if (dut.runEn == 1'b0) begin
                idle(int'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
